// File: rtl/gray_decoder_pkg.sv
// Shared constants and elaboration-time helpers for the Gray-to-binary decoder.
package gray_decoder_pkg;

    localparam int DEFAULT_WIDTH = 32;

    // Prefix-XOR depth: ceil(log2(width)), and zero stages for a single bit.
    function automatic int num_prefix_stages(input int width);
        if (width <= 1) begin
            return 0;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/gray_prefix_xor_stage.sv
// One level of the MSB-toward-LSB prefix-XOR network: each bit folds in the
// bit SHIFT positions above it, and bits without a partner pass straight through.
module gray_prefix_xor_stage #(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i + SHIFT < WIDTH) begin : g_pair
            assign o_data[i] = i_data[i] ^ i_data[i+SHIFT];
        end else begin : g_pass
            assign o_data[i] = i_data[i];
        end
    end

endmodule

// File: rtl/gray_decoder.sv
// Gray-to-binary decoder with a zero-latency combinational result and a
// one-cycle registered result qualified by o_valid.
module gray_decoder
    import gray_decoder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_gray,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_bin,
    output logic [WIDTH-1:0] o_bin_q,
    output logic             o_valid
);

    localparam int NUM_STAGES = num_prefix_stages(WIDTH);

    // After stage s, bit i holds the XOR of i_gray[i +: 2^(s+1)], clamped at the MSB.
    logic [WIDTH-1:0] stage_w [NUM_STAGES+1];

    assign stage_w[0] = i_gray;

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        gray_prefix_xor_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << s)
        ) u_stage (
            .i_data (stage_w[s]),
            .o_data (stage_w[s+1])
        );
    end

    assign o_bin = stage_w[NUM_STAGES];

    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] bin_q;
    logic             valid_d;
    logic             valid_q;

    always_comb begin
        bin_d   = bin_q;
        valid_d = i_valid;
        if (i_valid) begin
            bin_d = o_bin;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            valid_q <= valid_d;
        end
    end

    assign o_bin_q = bin_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed checks of gray_decoder at widths 16, 1, 5 and 32, covering both the
// combinational and registered paths.
module tb_gray_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Linear reference: XOR of all right-shifts of g, masked to w bits.
    function automatic logic [31:0] ref_decode(input logic [31:0] g, input int w);
        logic [31:0] mask;
        logic [31:0] r;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        g    = g & mask;
        r    = '0;
        for (int k = 0; k < w; k++) begin
            r ^= (g >> k);
        end
        return r & mask;
    endfunction

    // WIDTH = 16 instance drives the registered-path tests.
    logic        rst;
    logic [15:0] gray16;
    logic        valid16;
    logic [15:0] bin16;
    logic [15:0] bin16_q;
    logic        valid16_q;

    gray_decoder #(.WIDTH(16)) u_dut16 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_gray  (gray16),
        .i_valid (valid16),
        .o_bin   (bin16),
        .o_bin_q (bin16_q),
        .o_valid (valid16_q)
    );

    logic       gray1, bin1, bin1_q, valid1_q;
    logic [4:0] gray5, bin5, bin5_q;
    logic       valid5_q;
    logic [31:0] gray32, bin32, bin32_q;
    logic        valid32_q;

    gray_decoder #(.WIDTH(1)) u_dut1 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_gray  (gray1),
        .i_valid (1'b0),
        .o_bin   (bin1),
        .o_bin_q (bin1_q),
        .o_valid (valid1_q)
    );

    gray_decoder #(.WIDTH(5)) u_dut5 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_gray  (gray5),
        .i_valid (1'b0),
        .o_bin   (bin5),
        .o_bin_q (bin5_q),
        .o_valid (valid5_q)
    );

    gray_decoder #(.WIDTH(32)) u_dut32 (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_gray  (gray32),
        .i_valid (1'b0),
        .o_bin   (bin32),
        .o_bin_q (bin32_q),
        .o_valid (valid32_q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] gray;
        logic [15:0] bin;
    } spot_t;

    spot_t spots [4] = '{
        '{16'h0000, 16'h0000},
        '{16'h0003, 16'h0002},
        '{16'hC000, 16'h8000},
        '{16'h8000, 16'hFFFF}
    };

    initial begin
        rst     = 1'b1;
        valid16 = 1'b0;
        gray16  = '0;
        gray1   = 1'b0;
        gray5   = '0;
        gray32  = '0;

        // Combinational spot values.
        foreach (spots[i]) begin
            gray16 = spots[i].gray;
            #1;
            check($sformatf("spot16_%h", spots[i].gray), 32'(bin16), 32'(spots[i].bin));
        end

        // Exhaustive sweep through the standard encoder.
        for (int b = 0; b < 65536; b++) begin
            logic [15:0] bin_v;
            bin_v  = 16'(b);
            gray16 = bin_v ^ (bin_v >> 1);
            #1;
            check("sweep16_inv", 32'(bin16), 32'(bin_v));
            check("sweep16_ref", 32'(bin16), ref_decode(32'(gray16), 16));
        end

        // Reset held two cycles, with i_valid asserted to show it is ignored.
        rst     = 1'b1;
        valid16 = 1'b1;
        gray16  = 16'h8000;
        tick();
        tick();
        check("rst_valid", 32'(valid16_q), 32'd0);
        check("rst_bin_q", 32'(bin16_q), 32'd0);
        check("rst_comb_unaffected", 32'(bin16), 32'h0000_FFFF);

        // Idle cycle after reset: nothing valid yet.
        rst     = 1'b0;
        valid16 = 1'b0;
        tick();
        check("idle_valid", 32'(valid16_q), 32'd0);
        check("idle_bin_q", 32'(bin16_q), 32'd0);

        // First valid sample appears one cycle later.
        gray16  = 16'h0003;
        valid16 = 1'b1;
        tick();
        check("first_valid", 32'(valid16_q), 32'd1);
        check("first_bin_q", 32'(bin16_q), 32'h0002);

        gray16 = 16'hC000;
        tick();
        check("c000_valid", 32'(valid16_q), 32'd1);
        check("c000_bin_q", 32'(bin16_q), 32'h8000);

        // Hold when i_valid drops.
        gray16  = 16'h0001;
        valid16 = 1'b0;
        tick();
        check("hold_valid", 32'(valid16_q), 32'd0);
        check("hold_bin_q", 32'(bin16_q), 32'h8000);
        tick();
        check("hold2_bin_q", 32'(bin16_q), 32'h8000);

        // Back-to-back valid data.
        gray16  = 16'h8000;
        valid16 = 1'b1;
        tick();
        check("b2b_bin_q", 32'(bin16_q), 32'hFFFF);

        // Reset at the same edge as a valid sample discards it.
        gray16 = 16'h0003;
        rst    = 1'b1;
        tick();
        check("midrst_valid", 32'(valid16_q), 32'd0);
        check("midrst_bin_q", 32'(bin16_q), 32'd0);
        rst = 1'b0;
        tick();
        check("after_midrst_bin_q", 32'(bin16_q), 32'h0002);
        valid16 = 1'b0;

        // WIDTH = 1: identity.
        gray1 = 1'b0;
        #1;
        check("w1_zero", 32'(bin1), 32'd0);
        gray1 = 1'b1;
        #1;
        check("w1_one", 32'(bin1), 32'd1);

        // Boundary vectors for WIDTH = 5 and 32.
        gray5 = 5'b10000;
        #1;
        check("w5_msb", 32'(bin5), 32'h1F);
        gray5 = 5'b00000;
        #1;
        check("w5_zero", 32'(bin5), 32'h00);
        gray32 = 32'h8000_0000;
        #1;
        check("w32_msb", bin32, 32'hFFFF_FFFF);
        gray32 = 32'h0000_0003;
        #1;
        check("w32_3", bin32, 32'h0000_0002);

        // Random vectors against the linear reference.
        for (int n = 0; n < 300; n++) begin
            gray1  = 1'($urandom_range(0, 1));
            gray5  = 5'($urandom_range(0, 31));
            gray32 = $urandom;
            #1;
            check("w1_rand", 32'(bin1), 32'(gray1));
            check("w5_rand", 32'(bin5), ref_decode(32'(gray5), 5));
            check("w32_rand", bin32, ref_decode(gray32, 32));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gray_decoder.md
Name:
gray_decoder

Overview:
- Converts a Gray-encoded bit vector to its binary equivalent. Exact inverse of the std Gray encoder (gray = bin ^ (bin >> 1)).
- Provides two outputs:
  - a zero-latency combinational result;
  - a one-cycle registered result with a valid qualifier, for timing-critical consumers such as CDC pointer synchronizers in async FIFOs.

Parameters:
- WIDTH, 32, input/output vector width in bits; legal range is 1 or greater.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_gray  input  WIDTH  Gray-encoded input vector.
- i_valid  input  1  qualifies i_gray for the registered path.
- o_bin  output  WIDTH  combinational binary result of i_gray.
- o_bin_q  output  WIDTH  registered binary result.
- o_valid  output  1  registered copy of i_valid; qualifies o_bin_q.

Behaviour:
- Decode rule: o_bin[i] = XOR of i_gray[j] for all j >= i, for i = 0..WIDTH-1.
  - Equivalently, o_bin = XOR over k = 0..WIDTH-1 of (i_gray >> k).
  - MSB passes straight through: o_bin[WIDTH-1] = i_gray[WIDTH-1].
- Combinational path:
  - o_bin depends only on i_gray; no clock or reset involvement.
  - Settles within the same delta/timestep as an i_gray change.
  - Implemented as a log2(WIDTH)-depth prefix-XOR network from MSB toward LSB. Stage s XORs each bit with the bit 2^s positions above it; bits with no partner pass through. Number of stages = ceil(log2(WIDTH)); zero stages when WIDTH = 1.
  - Must equal the linear-chain result bit-for-bit for every input.
- Registered path:
  - On each rising i_clk edge with i_rst = 0:
    - o_valid <= i_valid.
    - If i_valid = 1, o_bin_q <= o_bin.
    - If i_valid = 0, o_bin_q holds its previous value.
  - Latency: exactly 1 cycle from i_gray/i_valid sampled to o_bin_q/o_valid.
- Reset:
  - When i_rst = 1 at a rising edge: o_bin_q <= 0 and o_valid <= 0, regardless of i_valid.
  - Reset asserted mid-stream discards the in-flight value.
  - The first valid output appears 1 cycle after the first i_valid = 1 following reset deassertion.
  - o_bin is unaffected by reset.
- Boundaries:
  - WIDTH = 1: o_bin = i_gray.
  - All-zero input decodes to all-zero output.
  - i_gray with only the MSB set decodes to all ones.
  - No X propagation from unused logic. Pure bitwise logic, so no overflow or wrap-around conditions exist.

Decomposition:
- No shared package is required.
- Sub-module gray_prefix_xor_stage, parameters WIDTH and SHIFT:
  - out[i] = in[i] ^ in[i+SHIFT] when i+SHIFT < WIDTH, else in[i].
  - Instantiated ceil(log2(WIDTH)) times via generate, with SHIFT = 1, 2, 4, ...
- The top level holds the stage chain, the output register and the valid register.

Test Plan:
- WIDTH=16, sweep i_gray via encoder from bin = 0..65535 -> o_bin equals original bin, and equals the XOR-of-shifts reference model, on every value.
- WIDTH=16 spot values:
  - i_gray 16'h0000 -> o_bin 16'h0000
  - i_gray 16'h0003 -> o_bin 16'h0002
  - i_gray 16'hC000 -> o_bin 16'h8000
  - i_gray 16'h8000 -> o_bin 16'hFFFF
- Registered path: hold i_rst=1 for 2 cycles, then i_gray=16'h0003 with i_valid=1 -> next cycle o_valid=1 and o_bin_q=16'h0002; during reset o_valid=0 and o_bin_q=0.
- Hold behaviour: valid sample 16'hC000, then i_valid=0 with i_gray=16'h0001 -> o_bin_q stays 16'h8000, o_valid=0.
- Reset mid-stream: i_valid=1 with i_rst=1 at the same edge -> o_valid=0 and o_bin_q=0 next cycle.
- Widths 1, 5 (non-power-of-2) and 32: random i_gray -> o_bin matches the reference model. WIDTH=1 case: o_bin = i_gray.
